sata_tx_gear3216: RTL

Transmit-side gearbox for the SATA host PHY. It accepts 32-bit dwords from the link layer and emits 16-bit words plus K-flags to the transceiver at the 16-bit word rate. It inserts ALIGNp bursts at a fixed dword period, and fills empty dword slots with a fill primitive so the line never starves. It is the counterpart of the receive elastic buffer, which later deletes or duplicates the ALIGNp this block produces.

---
 rtl/sata_prims_pkg.sv | 21 ++
 rtl/sata_tx_skid.sv | 34 +++
 rtl/sata_tx_gear3216.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sata_prims_pkg.sv
// Shared SATA primitive constants, used by the TX gearbox and the RX elastic buffer.
package sata_prims_pkg;

  localparam logic [31:0] ALIGN_PRIM   = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC_PRIM    = 32'hB5B5957C;
  localparam logic [3:0]  PRIM_CHARISK = 4'h1;

  // Which dword the gearbox places into the current slot.
  typedef enum logic [1:0] {
    SEL_ALIGN = 2'd0,
    SEL_DATA  = 2'd1,
    SEL_FILL  = 2'd2
  } dword_sel_e;

  // Word phase within a dword: low half goes out first.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_e;

endpackage

// File: rtl/sata_tx_skid.sv
// One-entry holding register between the link layer and the TX gearbox.
// A load and a consume at the same edge keep the register full with the new
// dword, so streaming never inserts a bubble.
module sata_tx_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [3:0]  charisk_in,
  input  logic        valid_in,
  input  logic        consume,
  output logic        ready_out,
  output logic        hold_v,
  output logic [31:0] hold_d,
  output logic [3:0]  hold_k
);

  assign ready_out = !hold_v || consume;

  // Holding register: load on handshake, otherwise drain on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v <= 1'b0;
      hold_d <= '0;
      hold_k <= '0;
    end else if (valid_in && ready_out) begin
      hold_v <= 1'b1;
      hold_d <= data_in;
      hold_k <= charisk_in;
    end else if (consume) begin
      hold_v <= 1'b0;
    end
  end

endmodule

// File: rtl/sata_tx_gear3216.sv
// SATA TX gearbox: 32-bit dwords in, 16-bit words + K flags out, one word per
// clk. Inserts an ALIGNp burst at the start of every ALIGN_PERIOD dword slots
// and fills empty slots with FILL_PRIM.
// Optional build macro: SATA_TX_GEAR_STATS_EN enables the stat_align/stat_fill
// counters; without it both ports are tied to zero.
module sata_tx_gear3216
  import sata_prims_pkg::*;
#(
  parameter int unsigned  ALIGN_PERIOD = 256,
  parameter int unsigned  ALIGN_BURST  = 2,
  parameter logic [31:0]  FILL_PRIM    = SYNC_PRIM
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        align_only,
  input  logic [31:0] data_in,
  input  logic [3:0]  charisk_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [15:0] data_out,
  output logic [1:0]  charisk_out,
  output logic        msb_out,
  output logic        align_sent,
  output logic        underrun,
  output logic [31:0] stat_align,
  output logic [31:0] stat_fill
);

  localparam int unsigned CNT_W = $clog2(ALIGN_PERIOD);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(ALIGN_BURST);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(ALIGN_BURST - 1);

  phase_e           phase;
  logic [CNT_W-1:0] cnt;

  logic        hold_v;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;
  logic        consume;

  dword_sel_e  sel_kind;
  logic [31:0] sel_d;
  logic [3:0]  sel_k;
  logic        burst_end;
  logic        fill_slot;

  logic [15:0] upper_d;
  logic [1:0]  upper_k;

  sata_tx_skid u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .charisk_in (charisk_in),
    .valid_in   (valid_in),
    .consume    (consume),
    .ready_out  (ready_out),
    .hold_v     (hold_v),
    .hold_d     (hold_d),
    .hold_k     (hold_k)
  );

  // Slot selection for the dword that starts at the next low-phase edge.
  always_comb begin
    sel_kind  = SEL_FILL;
    sel_d     = FILL_PRIM;
    sel_k     = PRIM_CHARISK;
    consume   = 1'b0;
    burst_end = 1'b0;
    fill_slot = 1'b0;
    if (align_only || (cnt < BURST_C)) begin
      sel_kind = SEL_ALIGN;
    end else if (hold_v) begin
      sel_kind = SEL_DATA;
    end
    case (sel_kind)
      SEL_ALIGN: begin
        sel_d = ALIGN_PRIM;
        sel_k = PRIM_CHARISK;
      end
      SEL_DATA: begin
        sel_d = hold_d;
        sel_k = hold_k;
      end
      default: begin
        sel_d = FILL_PRIM;
        sel_k = PRIM_CHARISK;
      end
    endcase
    consume   = (phase == PH_LOW) && (sel_kind == SEL_DATA);
    // Continuous ALIGNp under align_only is not a periodic burst.
    burst_end = (sel_kind == SEL_ALIGN) && !align_only && (cnt == LAST_C);
    fill_slot = (sel_kind == SEL_FILL);
  end

  // Word phase and slot counter; align_only parks the counter at slot 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= PH_LOW;
      cnt   <= '0;
    end else begin
      phase <= (phase == PH_LOW) ? PH_HIGH : PH_LOW;
      if (phase == PH_LOW) begin
        cnt <= align_only ? '0 : cnt + CNT_W'(1);
      end
    end
  end

  // Output register: low half plus flags on the low phase, latched upper half next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      charisk_out <= '0;
      msb_out     <= 1'b0;
      align_sent  <= 1'b0;
      underrun    <= 1'b0;
      upper_d     <= '0;
      upper_k     <= '0;
    end else if (phase == PH_LOW) begin
      data_out    <= sel_d[15:0];
      charisk_out <= sel_k[1:0];
      msb_out     <= 1'b0;
      align_sent  <= burst_end;
      underrun    <= fill_slot;
      upper_d     <= sel_d[31:16];
      upper_k     <= sel_k[3:2];
    end else begin
      data_out    <= upper_d;
      charisk_out <= upper_k;
      msb_out     <= 1'b1;
      align_sent  <= 1'b0;
      underrun    <= 1'b0;
    end
  end

`ifdef SATA_TX_GEAR_STATS_EN
  logic [31:0] stat_align_q;
  logic [31:0] stat_fill_q;

  // Wrapping event counters for completed ALIGN bursts and fill dwords.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_align_q <= '0;
      stat_fill_q  <= '0;
    end else if (phase == PH_LOW) begin
      if (burst_end) stat_align_q <= stat_align_q + 32'd1;
      if (fill_slot) stat_fill_q  <= stat_fill_q + 32'd1;
    end
  end

  assign stat_align = stat_align_q;
  assign stat_fill  = stat_fill_q;
`else
  assign stat_align = '0;
  assign stat_fill  = '0;
`endif

endmodule
